adder_ring_period_counter: RTL and testbench
============================================

Name: adder_ring_period_counter

Overview:
- Downstream measurement stage for the instrumented ripple adder.
- Consumes the adder's ring-oscillator output (chain_out), which is asynchronous to the system clock.
- Counts rising edges of that output over a programmable window of system-clock cycles, so firmware can derive adder propagation delay.
- Control and status connect to logic-analyser registers in the project wrapper.

Parameters:
- COUNT_W, 32, width of the edge counter and the count output.
- GATE_W, 32, width of the gate-length input and the internal window counter.
- SYNC_STAGES, 2, number of flops in the ring-input synchroniser; minimum 2.

Ports:
- wb_clk_i  input  1  system clock; all state is on its rising edge.
- wb_rst_i  input  1  reset, asynchronous, active-high.
- ring_in  input  1  ring-oscillator output from the instrumented adder (chain_out); asynchronous.
- start  input  1  single-cycle request to begin a measurement.
- abort  input  1  cancels a measurement in progress.
- gate_cycles  input  GATE_W  window length in clock cycles; sampled on an accepted start.
- busy  output  1  high while in ARM or COUNT.
- done  output  1  high in DONE; held until the next accepted start, an abort or a reset.
- count  output  COUNT_W  number of ring_in rising edges counted in the window.
- overflow  output  1  sticky; count saturated during this measurement.

Behaviour:
- Reset (async assert, sync release): state IDLE, busy=0, done=0, count=0, overflow=0, synchroniser and edge-detect flops all 0, window counter 0.
- Synchroniser: ring_in passes through SYNC_STAGES flops. A rising edge is detected when the last stage is 1 and its registered copy is 0.
- Frequency limit: only ring frequencies below f_clk/2 are measurable; faster inputs alias. Documented limit, not checked.
- States: IDLE, ARM, COUNT, DONE.
- IDLE or DONE, start=1, abort=0 (start accepted):
  - latch gate_cycles; clear count, overflow and done.
  - gate_cycles==0: next state DONE with count=0.
  - otherwise: next state ARM.
- ARM: lasts exactly SYNC_STAGES+1 cycles to flush stale synchroniser state. Edges detected in ARM are discarded. Then COUNT, with the window counter loaded to the latched gate_cycles.
- COUNT:
  - each cycle, count += 1 if an edge is detected.
  - the window counter decrements by 1 each cycle.
  - the cycle where the window counter equals 1 is the last sampled cycle; its edge is counted. Next state DONE.
  - exactly gate_cycles cycles are sampled.
- Saturation: an edge when count is all-ones leaves count unchanged and sets overflow=1. overflow stays set until the next accepted start or reset.
- DONE: done=1, busy=0, count and overflow frozen.
- start while busy: ignored, no effect on the window or count.
- abort while busy: next state IDLE, done=0, busy=0. count keeps its partial value and overflow keeps its value.
- abort in IDLE or DONE: next state IDLE, done=0, count unchanged.
- start and abort in the same cycle: abort wins, start is dropped.
- Latency: start accepted at cycle t gives busy=1 at t+1. Sampling covers cycles t+SYNC_STAGES+2 through t+SYNC_STAGES+1+gate_cycles. done=1 the following cycle.
- Reset mid-measurement: immediate return to reset values; no partial result is retained.
- gate_cycles changing after acceptance has no effect on the running measurement.

Decomposition:
- Shared package adder_meas_pkg:
  - state enum (IDLE, ARM, COUNT, DONE).
  - default widths (COUNT_W, GATE_W).
  - SYNC_STAGES default.
- Sub-module ring_edge_sync: parameterised SYNC_STAGES synchroniser plus registered rising-edge detector, 1-bit in, 1-bit edge pulse out. Reusable by other ring-measurement stages.
- Top level holds the FSM, window counter and saturating edge counter.

Test Plan:
- ring_in period 4 clk (2 high, 2 low), gate_cycles=100, start pulse -> busy 1 cycle later; done after 1+3+100 cycles; count=25, overflow=0.
- gate_cycles=0, start -> DONE next cycle; count=0, done=1, busy never asserts.
- COUNT_W=4, ring_in period 2 clk, gate_cycles=40 -> count=15, overflow=1. Next start with gate_cycles=4 -> overflow=0, count=2.
- ring_in period 4, gate 100, abort at 50th COUNT cycle -> IDLE next cycle, done=0, count ~12 (partial). start in the same cycle as abort -> no new measurement.
- Second start at sampled cycle 10 of a gate-50 run -> ignored; done exactly at original time, count matches the single-run value.
- Assert wb_rst_i asynchronously mid-COUNT between clock edges -> busy, done, count and overflow go 0 without a clock edge. A post-release run of gate 20 at period 4 gives count=5.

Source files
------------

// File: rtl/adder_meas_pkg.sv
// Shared types and default widths for the ripple-adder ring-oscillator measurement stages.
package adder_meas_pkg;

  typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} meas_state_e;

  localparam int COUNT_W_DEF     = 32;
  localparam int GATE_W_DEF      = 32;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/adder_ring_period_counter_if.sv
// Control/status bundle between the logic-analyser register wrapper and the period counter.
interface adder_ring_period_counter_if
  import adder_meas_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int GATE_W  = GATE_W_DEF
);
  logic               start;
  logic               abort;
  logic [GATE_W-1:0]  gate_cycles;
  logic               busy;
  logic               done;
  logic [COUNT_W-1:0] count;
  logic               overflow;

  modport master (output start, abort, gate_cycles, input busy, done, count, overflow);
  modport slave  (input start, abort, gate_cycles, output busy, done, count, overflow);
endinterface

// File: rtl/ring_edge_sync.sv
// Multi-flop synchroniser for an asynchronous ring-oscillator output plus rising-edge detect.
module ring_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ring_i,
  output logic edge_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ring_i};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~last_q;
endmodule

// File: rtl/adder_ring_period_counter.sv
// Counts ring-oscillator rising edges over a programmable window of clock cycles.
module adder_ring_period_counter
  import adder_meas_pkg::*;
#(
  parameter int COUNT_W     = COUNT_W_DEF,
  parameter int GATE_W      = GATE_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         ring_in,
  adder_ring_period_counter_if.slave   ctl
);
  meas_state_e        state_q;
  logic               busy_q, done_q, ovf_q, ovf_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [GATE_W-1:0]  win_q, gate_q;
  logic               edge_det;

  ring_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (wb_clk_i),
    .rst_i  (wb_rst_i),
    .ring_i (ring_in),
    .edge_o (edge_det)
  );

  // Saturating edge count; only COUNT cycles contribute.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (state_q == COUNT && edge_det) begin
      if (&count_q) ovf_d   = 1'b1;
      else          count_d = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      win_q   <= '0;
      gate_q  <= '0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (ctl.abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: if (ctl.start) begin
            gate_q  <= ctl.gate_cycles;
            count_q <= '0;
            ovf_q   <= 1'b0;
            // win_q doubles as the ARM flush counter: SYNC_STAGES..0 is SYNC_STAGES+1 cycles.
            win_q   <= GATE_W'(SYNC_STAGES);
            if (ctl.gate_cycles == '0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ARM;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
          ARM: begin
            if (win_q == '0) begin
              state_q <= COUNT;
              win_q   <= gate_q;
            end else begin
              win_q <= win_q - GATE_W'(1);
            end
          end
          COUNT: begin
            win_q <= win_q - GATE_W'(1);
            if (win_q == GATE_W'(1)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ctl.busy     = busy_q;
  assign ctl.done     = done_q;
  assign ctl.count    = count_q;
  assign ctl.overflow = ovf_q;
endmodule

// File: tb/tb_adder_ring_period_counter.sv
// Randomised and directed bench for adder_ring_period_counter against a sample-history model.
module tb_adder_ring_period_counter;
  localparam int S    = 2;
  localparam int CW   = 32;
  localparam int GW   = 32;
  localparam int MAXN = 20000;

  logic clk = 1'b0, rst = 1'b1, ring = 1'b0;
  always #5 clk = ~clk;

  adder_ring_period_counter_if #(.COUNT_W(CW), .GATE_W(GW)) bus  ();
  adder_ring_period_counter_if #(.COUNT_W(4),  .GATE_W(GW)) bus4 ();

  adder_ring_period_counter #(.COUNT_W(CW), .GATE_W(GW), .SYNC_STAGES(S)) dut (
    .wb_clk_i (clk), .wb_rst_i (rst), .ring_in (ring), .ctl (bus));
  adder_ring_period_counter #(.COUNT_W(4), .GATE_W(GW), .SYNC_STAGES(S)) dut4 (
    .wb_clk_i (clk), .wb_rst_i (rst), .ring_in (ring), .ctl (bus4));

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Ring stimulus: square wave of ring_per cycles (ring_hi high) or random samples.
  int ring_per = 4, ring_hi = 2, ph = 0;
  bit ring_rand = 1'b0;
  initial forever begin
    @(negedge clk);
    if (ring_rand) ring = 1'($urandom_range(0, 1));
    else begin
      if (ph >= ring_per) ph = 0;
      ring = (ph < ring_hi);
      ph   = (ph + 1) % ring_per;
    end
  end

  // Model: a measurement accepted at edge a with gate g counts rising edges of the
  // sampled ring history at indices a+2 .. a+g+1 (the synchroniser delay shifts the
  // window), is busy from edge a until done_at, and done from done_at onward.
  bit          rh [0:MAXN];
  int          n = 0, ma = 0, mg = 0, done_at = 0, mj;
  bit          run = 1'b0, was_busy, chk_en = 1'b0;
  logic [CW-1:0] mc = '0;
  bit          mov = 1'b0;

  always @(posedge clk) begin
    if (n < MAXN) n++;
    rh[n] = ring;
    if (rst) begin
      run = 1'b0; mc = '0; mov = 1'b0;
    end else begin
      if (run && mg > 0) begin
        mj = n - S;
        if (mj >= ma + 2 && mj <= ma + mg + 1 && rh[mj] && !rh[mj-1]) begin
          if (&mc) mov = 1'b1;
          else     mc  = mc + 1'b1;
        end
      end
      was_busy = run && (n - 1) < done_at;
      if (bus.abort) run = 1'b0;
      else if (bus.start && !was_busy) begin
        ma = n; mg = int'(bus.gate_cycles); mc = '0; mov = 1'b0; run = 1'b1;
        done_at = (mg == 0) ? n : n + S + mg + 1;
      end
    end
    #1;
    if (chk_en) begin
      chk("busy",     bus.busy,     run && n < done_at);
      chk("done",     bus.done,     run && n >= done_at);
      chk("count",    bus.count,    mc);
      chk("overflow", bus.overflow, mov);
    end
  end

  task automatic start_meas(input int g, input bit both);
    @(negedge clk);
    bus.start = 1'b1; bus.gate_cycles = GW'(g);
    if (both) begin bus4.start = 1'b1; bus4.gate_cycles = GW'(g); end
    @(negedge clk);
    bus.start = 1'b0; bus4.start = 1'b0;
    bus.gate_cycles = $urandom; bus4.gate_cycles = $urandom;
  endtask

  task automatic wait_done(input int maxc, output int k);
    k = 0;
    while (!bus.done && k < maxc) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) chk("done_timeout", bus.done, 1);
  endtask

  int k;
  initial begin
    bus.start = 0; bus.abort = 0; bus.gate_cycles = '0;
    bus4.start = 0; bus4.abort = 0; bus4.gate_cycles = '0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // period 4, gate 100
    start_meas(100, 0);
    chk("t1_busy_next", bus.busy, 1);
    wait_done(300, k);
    chk("t1_latency", k, S + 100 + 1);
    chk("t1_count", bus.count, 25);
    chk("t1_model", mc, 25);
    chk("t1_ovf", bus.overflow, 0);

    // gate 0 -> DONE immediately
    start_meas(0, 0);
    chk("t2_done", bus.done, 1);
    chk("t2_busy", bus.busy, 0);
    chk("t2_count", bus.count, 0);

    // saturation on the 4-bit counter, period 2
    ring_per = 2; ring_hi = 1;
    repeat (4) @(negedge clk);
    start_meas(40, 1);
    wait_done(300, k);
    chk("t3_count4", bus4.count, 15);
    chk("t3_ovf4", bus4.overflow, 1);
    chk("t3_count32", bus.count, 20);
    start_meas(4, 1);
    wait_done(300, k);
    chk("t3b_count4", bus4.count, 2);
    chk("t3b_ovf4", bus4.overflow, 0);

    // abort at the 50th COUNT cycle with a simultaneous start
    ring_per = 4; ring_hi = 2;
    repeat (4) @(negedge clk);
    start_meas(100, 0);
    repeat (S + 50) @(negedge clk);
    bus.abort = 1'b1; bus.start = 1'b1; bus.gate_cycles = 10;
    @(negedge clk);
    bus.abort = 1'b0; bus.start = 1'b0;
    chk("t4_busy", bus.busy, 0);
    chk("t4_done", bus.done, 0);
    chk("t4_partial", (bus.count >= 12 && bus.count <= 13), 1);
    repeat (5) @(negedge clk);
    chk("t4_no_restart", bus.busy, 0);

    // second start during a gate-50 run is ignored
    start_meas(50, 0);
    repeat (S + 10) @(negedge clk);
    bus.start = 1'b1; bus.gate_cycles = 5;
    @(negedge clk);
    bus.start = 1'b0;
    k = S + 11;
    while (!bus.done && k < 200) begin @(negedge clk); k++; end
    chk("t5_latency", k, S + 50 + 1);
    chk("t5_count", (bus.count >= 12 && bus.count <= 13), 1);

    // asynchronous reset mid-COUNT
    start_meas(100, 0);
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", bus.busy, 0);
    chk("t6_done", bus.done, 0);
    chk("t6_count", bus.count, 0);
    chk("t6_ovf", bus.overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    start_meas(20, 0);
    wait_done(100, k);
    chk("t6_post_count", bus.count, 5);

    // random ring samples and random control traffic
    ring_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus.start       = ($urandom_range(0, 7) == 0);
      bus.abort       = ($urandom_range(0, 39) == 0);
      bus.gate_cycles = GW'($urandom_range(0, 30));
    end
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    repeat (5) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
